// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - KxK sliding window generator over a raster pixel stream
// Optional CONV_FRAME_SYNC_EN adds the sof input for frame realignment.

module conv_window_buffer #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [BITS-1:0]                       pixel_in,
  input  logic                                  pixel_valid,
`ifdef CONV_FRAME_SYNC_EN
  input  logic                                  sof,
`endif
  output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window_out,
  output logic                                  window_valid
);

  localparam int K  = KERNEL_SIZE;
  localparam int NL = K - 1;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [BITS-1:0] r_line [NL][IMG_WIDTH];
  logic [BITS-1:0] r_win  [K][K];
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_valid;

  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic            w_accept;
  logic            w_sof;
  logic [BITS-1:0] w_tap    [NL];
  logic [BITS-1:0] w_newcol [K];

  assign w_accept = pixel_valid & ~rst;

`ifdef CONV_FRAME_SYNC_EN
  assign w_sof = sof & pixel_valid;
`else
  assign w_sof = 1'b0;
`endif

  // Effective position of the current pixel; sof relabels it as (0,0).
  always_comb begin
    w_col = r_col;
    w_row = r_row;
    if (w_sof) begin
      w_col = '0;
      w_row = '0;
    end
  end

  // Line buffers are addressed by column, so each tap is the pixel directly above.
  for (genvar j = 0; j < NL; j++) begin : g_tap
    assign w_tap[j] = r_line[j][w_col];
  end

  for (genvar r = 0; r < K; r++) begin : g_newcol
    if (r == K - 1) begin : g_cur
      assign w_newcol[r] = pixel_in;
    end else begin : g_buf
      assign w_newcol[r] = w_tap[K-2-r];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line[0][w_col] <= pixel_in;
      for (int j = 1; j < NL; j++) begin
        r_line[j][w_col] <= w_tap[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_valid <= pixel_valid && (w_row >= RW'(K-1)) && (w_col >= CW'(K-1));
      if (pixel_valid) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            r_win[r][c] <= r_win[r][c+1];
          end
          r_win[r][K-1] <= w_newcol[r];
        end
        if (w_col == CW'(IMG_WIDTH-1)) begin
          r_col <= '0;
          r_row <= (w_row == RW'(IMG_HEIGHT-1)) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_pack_r
    for (genvar c = 0; c < K; c++) begin : g_pack_c
      assign window_out[(r*K+c)*BITS +: BITS] = r_win[r][c];
    end
  end

  assign window_valid = r_valid;

endmodule
